// File: rtl/delta_pkg.sv
// Shared types and constants for the per-PU delta weight buffer.
package delta_pkg;

  localparam int LINE_BYTES_DEFAULT = 32;
  localparam int WEIGHT_ADDR_W      = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } wbuf_state_t;

endpackage

// File: rtl/delta_weight_fifo.sv
// Synchronous FIFO holding fetched weight lines; head entry is read straight
// from storage (no bypass), so a pushed line is visible the cycle after the push.
module delta_weight_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/delta_weight_buffer.sv
// Per-PU weight buffer: fetches num_lines weight lines from the weight manager
// one request at a time, queues them locally and presents them to the PE array.
module delta_weight_buffer
  import delta_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEFAULT,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_lines,
  output logic                     wb_sram_read,
  output logic [WEIGHT_ADDR_W-1:0] wb_sram_address,
  input  logic                     wb_sram_ready,
  input  logic [LINE_BYTES*8-1:0]  wb_sram_data,
  input  logic                     pe_rd_en,
  output logic [LINE_BYTES*8-1:0]  pe_data,
  output logic                     pe_valid,
  output logic                     busy,
  output logic                     cycle_done
);

  localparam int DATA_W = LINE_BYTES * 8;

  wbuf_state_t              r_state;
  wbuf_state_t              w_state_next;
  logic                     r_read;
  logic [WEIGHT_ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]         r_num_lines;
  logic [CNT_W-1:0]         r_fetch_cnt;
  logic                     w_push;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;

  // Only a ready seen while requesting is a real grant.
  assign w_push = (r_state == REQ) && wb_sram_ready;

  delta_weight_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock     (clock),
    .i_rst_n     (reset),
    .i_push      (w_push),
    .i_push_data (wb_sram_data),
    .i_pop       (pe_rd_en),
    .o_head      (pe_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_read      <= 1'b0;
      r_addr      <= '0;
      r_num_lines <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_read  <= (w_state_next == REQ);
      if ((r_state == IDLE) && start) begin
        r_num_lines <= num_lines;
        r_fetch_cnt <= '0;
        r_addr      <= '0;
      end else if (w_push) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
        r_addr      <= r_addr + WEIGHT_ADDR_W'(LINE_BYTES);
      end
    end
  end

  // CAPTURE forces one low cycle on read so the manager never re-serves a grant.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = (num_lines == '0) ? DONE : REQ;
      end
      REQ: begin
        if (wb_sram_ready) w_state_next = CAPTURE;
      end
      CAPTURE: begin
        if (r_fetch_cnt == r_num_lines) w_state_next = DRAIN;
        else if (w_fifo_full)           w_state_next = HOLD;
        else                            w_state_next = REQ;
      end
      HOLD: begin
        if (!w_fifo_full) w_state_next = REQ;
      end
      DRAIN: begin
        if (w_fifo_empty) w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (r_state != IDLE);
    cycle_done = (r_state == DONE);
    pe_valid   = !w_fifo_empty;
  end

  assign wb_sram_read    = r_read;
  assign wb_sram_address = r_addr;

endmodule

// File: tb/tb_delta_weight_buffer.sv
// Directed bench for delta_weight_buffer: hand-computed addresses, data order,
// handshake spacing, full/hold behaviour, spurious inputs and async reset.
module tb_delta_weight_buffer;

  localparam int LB     = 32;
  localparam int DATA_W = LB * 8;
  localparam int CNT_W  = 16;

  logic              clock;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  num_lines;
  logic              wb_sram_read;
  logic [31:0]       wb_sram_address;
  logic              wb_sram_ready;
  logic [DATA_W-1:0] wb_sram_data;
  logic              pe_rd_en;
  logic [DATA_W-1:0] pe_data;
  logic              pe_valid;
  logic              busy;
  logic              cycle_done;

  int checks = 0;
  int errors = 0;

  delta_weight_buffer #(
    .LINE_BYTES (LB),
    .DEPTH      (8),
    .CNT_W      (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .num_lines       (num_lines),
    .wb_sram_read    (wb_sram_read),
    .wb_sram_address (wb_sram_address),
    .wb_sram_ready   (wb_sram_ready),
    .wb_sram_data    (wb_sram_data),
    .pe_rd_en        (pe_rd_en),
    .pe_data         (pe_data),
    .pe_valid        (pe_valid),
    .busy            (busy),
    .cycle_done      (cycle_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(i) * 32'h0101_0101;
    return {8{w}};
  endfunction

  // Wait for read, check address, hold read high for lat cycles, then grant.
  // Returns in the CAPTURE cycle.
  task automatic serve(input int lat, input logic [DATA_W-1:0] d,
                       input logic [31:0] exp_addr, input bit pop_too);
    int n;
    n = 0;
    while (!wb_sram_read && n < 40) begin
      tick();
      n++;
    end
    chk("read_rise", DATA_W'(wb_sram_read), DATA_W'(1));
    chk("req_addr", DATA_W'(wb_sram_address), DATA_W'(exp_addr));
    for (int k = 0; k < lat; k++) begin
      tick();
      chk("read_held", DATA_W'(wb_sram_read), DATA_W'(1));
    end
    wb_sram_ready = 1'b1;
    wb_sram_data  = d;
    if (pop_too) pe_rd_en = 1'b1;
    tick();
    wb_sram_ready = 1'b0;
    wb_sram_data  = {8{32'hBAD0_BAD0}};
    if (pop_too) pe_rd_en = 1'b0;
    chk("read_low_capture", DATA_W'(wb_sram_read), DATA_W'(0));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!cycle_done && n < 60) begin
      tick();
      n++;
    end
    chk("done_seen", DATA_W'(cycle_done), DATA_W'(1));
    tick();
    chk("done_pulse_end", DATA_W'(cycle_done), DATA_W'(0));
    chk("idle_busy", DATA_W'(busy), DATA_W'(0));
  endtask

  task automatic kick(input int n);
    num_lines = CNT_W'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    num_lines     = '0;
    wb_sram_ready = 1'b0;
    wb_sram_data  = '0;
    pe_rd_en      = 1'b0;
    #12;
    chk("rst_read", DATA_W'(wb_sram_read), DATA_W'(0));
    chk("rst_addr", DATA_W'(wb_sram_address), DATA_W'(0));
    chk("rst_busy", DATA_W'(busy), DATA_W'(0));
    chk("rst_valid", DATA_W'(pe_valid), DATA_W'(0));
    chk("rst_done", DATA_W'(cycle_done), DATA_W'(0));
    tick();
    reset = 1'b1;
    tick();

    // 3 lines, ready 2 cycles after read, PE popping continuously
    pe_rd_en = 1'b1;
    kick(3);
    for (int i = 0; i < 3; i++) begin
      serve(2, mk(i), 32'(i * LB), 1'b0);
      chk("t1_valid", DATA_W'(pe_valid), DATA_W'(1));
      chk("t1_head", pe_data, mk(i));
      if (i < 2) begin
        tick();
        chk("t1_read_back", DATA_W'(wb_sram_read), DATA_W'(1));
      end
    end
    wait_done();
    pe_rd_en = 1'b0;

    // 10 lines into an 8-deep FIFO with no pops
    kick(10);
    for (int i = 0; i < 8; i++) begin
      serve(0, mk(10 + i), 32'(i * LB), 1'b0);
      if (i < 7) tick();
    end
    repeat (4) tick();
    chk("t2_hold_read", DATA_W'(wb_sram_read), DATA_W'(0));
    chk("t2_hold_busy", DATA_W'(busy), DATA_W'(1));
    chk("t2_head0", pe_data, mk(10));
    pe_rd_en = 1'b1;
    tick();
    chk("t2_head1", pe_data, mk(11));
    tick();
    pe_rd_en = 1'b0;
    serve(0, mk(18), 32'd256, 1'b0);
    tick();
    // push and pop together at 7/8 occupancy
    serve(0, mk(19), 32'd288, 1'b1);
    chk("t2_head_adv", pe_data, mk(13));
    chk("t2_final_addr", DATA_W'(wb_sram_address), DATA_W'(320));
    for (int k = 13; k < 20; k++) begin
      chk("t2_drain_valid", DATA_W'(pe_valid), DATA_W'(1));
      chk("t2_drain_data", pe_data, mk(k));
      pe_rd_en = 1'b1;
      tick();
    end
    pe_rd_en = 1'b0;
    chk("t2_empty", DATA_W'(pe_valid), DATA_W'(0));
    wait_done();

    // num_lines = 0
    kick(0);
    chk("t3_done", DATA_W'(cycle_done), DATA_W'(1));
    chk("t3_no_read", DATA_W'(wb_sram_read), DATA_W'(0));
    tick();
    chk("t3_done_end", DATA_W'(cycle_done), DATA_W'(0));
    chk("t3_idle", DATA_W'(busy), DATA_W'(0));
    chk("t3_no_read2", DATA_W'(wb_sram_read), DATA_W'(0));

    // spurious ready in IDLE, pop while empty, spurious ready in CAPTURE
    wb_sram_ready = 1'b1;
    wb_sram_data  = mk(99);
    pe_rd_en      = 1'b1;
    tick();
    wb_sram_ready = 1'b0;
    pe_rd_en      = 1'b0;
    chk("t4_idle_ready", DATA_W'(pe_valid), DATA_W'(0));
    chk("t4_idle_busy", DATA_W'(busy), DATA_W'(0));
    kick(2);
    serve(1, mk(40), 32'd0, 1'b0);
    wb_sram_ready = 1'b1;
    wb_sram_data  = mk(98);
    tick();
    wb_sram_ready = 1'b0;
    chk("t4_rereq", DATA_W'(wb_sram_read), DATA_W'(1));
    chk("t4_head", pe_data, mk(40));
    serve(0, mk(41), 32'd32, 1'b0);
    pe_rd_en = 1'b1;
    chk("t4_pop_a", pe_data, mk(40));
    tick();
    chk("t4_pop_b", pe_data, mk(41));
    tick();
    pe_rd_en = 1'b0;
    chk("t4_count2", DATA_W'(pe_valid), DATA_W'(0));
    wait_done();

    // async reset while requesting
    kick(3);
    serve(0, mk(50), 32'd0, 1'b0);
    tick();
    chk("t5_req", DATA_W'(wb_sram_read), DATA_W'(1));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_read_async", DATA_W'(wb_sram_read), DATA_W'(0));
    chk("t5_busy", DATA_W'(busy), DATA_W'(0));
    chk("t5_fifo_empty", DATA_W'(pe_valid), DATA_W'(0));
    wb_sram_ready = 1'b1;
    tick();
    wb_sram_ready = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5_after_rst", DATA_W'(pe_valid), DATA_W'(0));
    pe_rd_en = 1'b1;
    kick(1);
    serve(1, mk(60), 32'd0, 1'b0);
    chk("t5_head", pe_data, mk(60));
    wait_done();
    pe_rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
